// File: rtl/clock_time_ctrl.sv
// 24-hour BCD time-of-day clock with a RUN/SET_HOUR/SET_MIN mode FSM,
// a one-second prescaler and a sticky hour:minute alarm.
module clock_time_ctrl #(
   parameter int unsigned TICKS_PER_SEC = 100000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       mode_btn,
   input  logic       inc_btn,
   input  logic       alarm_en,
   input  logic [7:0] alarm_hour,
   input  logic [7:0] alarm_min,
   output logic [7:0] hours,
   output logic [7:0] minutes,
   output logic [7:0] seconds,
   output logic [1:0] mode,
   output logic       sec_tick,
   output logic       alarm
);

   localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } mode_e;

   mode_e         state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    hours_q, hours_d;
   logic [7:0]    min_q, min_d;
   logic [7:0]    sec_q, sec_d;
   logic          tick_q, tick_d;
   logic          alarm_q, alarm_d;

   logic [8:0]    sec_inc, min_inc;
   logic [7:0]    hour_inc;
   logic          alarm_set;

   // Returns {carry, next} for a 00-59 BCD field.
   function automatic logic [8:0] inc_bcd60(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         if (v[7:4] == 4'd5) return {1'b1, 8'h00};
         else                return {1'b0, v[7:4] + 4'd1, 4'd0};
      end
      return {1'b0, v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] inc_bcd24(input logic [7:0] v);
      if (v == 8'h23)        return 8'h00;
      if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign sec_inc  = inc_bcd60(sec_q);
   assign min_inc  = inc_bcd60(min_q);
   assign hour_inc = inc_bcd24(hours_q);

   always_comb begin
      state_d   = state_q;
      presc_d   = '0;
      hours_d   = hours_q;
      min_d     = min_q;
      sec_d     = sec_q;
      tick_d    = 1'b0;
      alarm_set = 1'b0;
      case (state_q)
         RUN: begin
            if (presc_q == PRESC_MAX) begin
               tick_d = 1'b1;
               sec_d  = sec_inc[7:0];
               if (sec_inc[8]) begin
                  min_d = min_inc[7:0];
                  if (min_inc[8]) hours_d = hour_inc;
               end
               // Compare against the post-carry time so the match lands on HH:MM:00.
               alarm_set = alarm_en && (sec_d == 8'h00) &&
                           (hours_d == alarm_hour) && (min_d == alarm_min);
            end else begin
               presc_d = presc_q + PW'(1);
            end
            if (mode_btn) begin
               state_d = SET_HOUR;
               presc_d = '0;
            end
         end
         SET_HOUR: begin
            if (mode_btn)     state_d = SET_MIN;
            else if (inc_btn) hours_d = hour_inc;
         end
         SET_MIN: begin
            if (mode_btn) begin
               state_d = RUN;
               sec_d   = 8'h00;
            end else if (inc_btn) begin
               min_d = min_inc[7:0];
            end
         end
         default: state_d = RUN;
      endcase
      if (mode_btn || inc_btn || !alarm_en) alarm_d = 1'b0;
      else                                  alarm_d = alarm_q || alarm_set;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
         presc_q <= '0;
         hours_q <= '0;
         min_q   <= '0;
         sec_q   <= '0;
         tick_q  <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         hours_q <= hours_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         tick_q  <= tick_d;
         alarm_q <= alarm_d;
      end
   end

   assign hours    = hours_q;
   assign minutes  = min_q;
   assign seconds  = sec_q;
   assign mode     = state_q;
   assign sec_tick = tick_q;
   assign alarm    = alarm_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with TICKS_PER_SEC=4: vector table plus
// hand-written sequences for rollover, set modes, alarm and async reset.
module tb_clock_time_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       mode_btn, inc_btn, alarm_en;
   logic [7:0] alarm_hour, alarm_min;
   logic [7:0] hours, minutes, seconds;
   logic [1:0] mode;
   logic       sec_tick, alarm;

   int passed = 0;
   int total  = 0;

   clock_time_ctrl #(.TICKS_PER_SEC(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mode_btn   (mode_btn),
      .inc_btn    (inc_btn),
      .alarm_en   (alarm_en),
      .alarm_hour (alarm_hour),
      .alarm_min  (alarm_min),
      .hours      (hours),
      .minutes    (minutes),
      .seconds    (seconds),
      .mode       (mode),
      .sec_tick   (sec_tick),
      .alarm      (alarm)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       mb;
      logic       ib;
      logic [7:0] eh;
      logic [7:0] em;
      logic [7:0] es;
      logic [1:0] emode;
      logic       etick;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_time(input string name, input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s);
      check({name, ".hours"},   hours,   h);
      check({name, ".minutes"}, minutes, m);
      check({name, ".seconds"}, seconds, s);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic mb, input logic ib);
      mode_btn = mb;
      inc_btn  = ib;
      step();
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
   endtask

   // Called just after a clock edge; reset pulse stays clear of the next edge.
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
   endtask

   task automatic set_hm(input int h, input int m);
      pulse(1'b1, 1'b0);
      repeat (h) pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      repeat (m) pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h10, 2'd0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h10, 2'd1, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h10, 2'd1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h10, 2'd1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h10, 2'd1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h10, 2'd1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h10, 2'd1, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 8'h02, 8'h00, 8'h10, 2'd1, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 8'h02, 8'h00, 8'h10, 2'd2, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 8'h02, 8'h01, 8'h10, 2'd2, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 8'h02, 8'h02, 8'h10, 2'd2, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 8'h02, 8'h02, 8'h00, 2'd0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 8'h02, 8'h02, 8'h00, 2'd0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 8'h02, 8'h02, 8'h00, 2'd0, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 8'h02, 8'h02, 8'h00, 2'd0, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 8'h02, 8'h02, 8'h01, 2'd0, 1'b1};
      vecs[16] = '{1'b0, 1'b0, 8'h02, 8'h02, 8'h01, 2'd0, 1'b0};

      reset_n    = 1'b0;
      mode_btn   = 1'b0;
      inc_btn    = 1'b0;
      alarm_en   = 1'b0;
      alarm_hour = 8'h00;
      alarm_min  = 8'h00;
      #2;
      check_time("reset", 8'h00, 8'h00, 8'h00);
      check("reset.mode", mode, 2'd0);
      check("reset.sec_tick", sec_tick, 1'b0);
      check("reset.alarm", alarm, 1'b0);

      // Free run: tick on every 4th edge, 10 seconds after 40 edges.
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         check($sformatf("run40.tick[%0d]", k), sec_tick, (k % 4) == 0);
      end
      check_time("run40", 8'h00, 8'h00, 8'h10);

      // Table: RUN inc ignored, mode+inc priority, set modes, SET_MIN->RUN restart.
      for (int i = 0; i < 17; i++) begin
         mode_btn = vecs[i].mb;
         inc_btn  = vecs[i].ib;
         step();
         mode_btn = 1'b0;
         inc_btn  = 1'b0;
         check_time($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em, vecs[i].es);
         check($sformatf("vec%0d.mode", i), mode, vecs[i].emode);
         check($sformatf("vec%0d.tick", i), sec_tick, vecs[i].etick);
         check($sformatf("vec%0d.alarm", i), alarm, 1'b0);
      end

      // Hour and minute wraparound through the set modes.
      do_reset();
      repeat (8) step();
      check_time("pre_set", 8'h00, 8'h00, 8'h02);
      pulse(1'b1, 1'b0);
      repeat (25) pulse(1'b0, 1'b1);
      check("set25.hours", hours, 8'h01);
      check("set25.mode", mode, 2'd1);
      pulse(1'b1, 1'b0);
      repeat (61) pulse(1'b0, 1'b1);
      check_time("set61", 8'h01, 8'h01, 8'h02);
      check("set61.mode", mode, 2'd2);
      pulse(1'b1, 1'b0);
      check_time("set_done", 8'h01, 8'h01, 8'h00);
      check("set_done.mode", mode, 2'd0);

      // Full-day rollover 23:59:59 -> 00:00:00.
      do_reset();
      set_hm(23, 59);
      repeat (236) step();
      check_time("pre_midnight", 8'h23, 8'h59, 8'h59);
      repeat (3) step();
      check("pre_midnight.tick", sec_tick, 1'b0);
      step();
      check_time("midnight", 8'h00, 8'h00, 8'h00);
      check("midnight.tick", sec_tick, 1'b1);

      // Hour tens carry 09:59:59 -> 10:00:00.
      do_reset();
      set_hm(9, 59);
      repeat (236) step();
      check_time("pre_ten", 8'h09, 8'h59, 8'h59);
      repeat (4) step();
      check_time("ten", 8'h10, 8'h00, 8'h00);

      // Alarm at 00:01:00, sticky, cleared by inc_btn.
      do_reset();
      alarm_en  = 1'b1;
      alarm_min = 8'h01;
      repeat (239) step();
      check_time("pre_alarm", 8'h00, 8'h00, 8'h59);
      check("pre_alarm.alarm", alarm, 1'b0);
      step();
      check_time("alarm_hit", 8'h00, 8'h01, 8'h00);
      check("alarm_hit.alarm", alarm, 1'b1);
      repeat (5) step();
      check("alarm_sticky", alarm, 1'b1);
      pulse(1'b0, 1'b1);
      check("alarm_clr_inc", alarm, 1'b0);
      check("alarm_clr_inc.mode", mode, 2'd0);

      // Matching time produced in SET modes must not raise the alarm.
      do_reset();
      alarm_hour = 8'h01;
      alarm_min  = 8'h00;
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      step();
      check("set_match.hours", hours, 8'h01);
      check("set_match.alarm", alarm, 1'b0);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      step();
      check_time("set_match_run", 8'h01, 8'h00, 8'h00);
      check("set_match_run.alarm", alarm, 1'b0);
      alarm_en = 1'b0;

      // Async reset mid-second while in SET_MIN, then restart timing.
      do_reset();
      repeat (6) step();
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      check_time("pre_areset", 8'h01, 8'h01, 8'h01);
      check("pre_areset.mode", mode, 2'd2);
      #2;
      reset_n = 1'b0;
      #1;
      check_time("areset", 8'h00, 8'h00, 8'h00);
      check("areset.mode", mode, 2'd0);
      check("areset.tick", sec_tick, 1'b0);
      check("areset.alarm", alarm, 1'b0);
      #1;
      reset_n = 1'b1;
      repeat (3) step();
      check("resume.tick3", sec_tick, 1'b0);
      step();
      check("resume.tick4", sec_tick, 1'b1);
      check_time("resume", 8'h00, 8'h00, 8'h01);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
